// File: rtl/time_of_day_counter.sv
// HH:MM:SS BCD time base advanced by synchronized slow_clk ticks, with a two-key hour/minute set mode.
// All state moves on the clk_in edge where tick=1 (3 edges after slow_clk rises); no backpressure.
module time_of_day_counter #(
  parameter int TICKS_PER_SEC = 10
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       slow_clk,
  input  logic       key_mode_n,
  input  logic       key_inc_n,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic [1:0] mode,
  output logic       blink,
  output logic       sec_pulse
);

  localparam int SUB_W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int HALF  = TICKS_PER_SEC / 2;
  localparam int BLK_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICKS_PER_SEC - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(HALF - 1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } mode_e;

  logic slow_s1_q, slow_s2_q, slow_prev_q;
  logic mode_s1_q, mode_s2_q, mode_smp_q;
  logic inc_s1_q, inc_s2_q, inc_smp_q;

  logic [7:0]       hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
  mode_e            mode_q, mode_d;
  logic             blink_q, blink_d;
  logic             sec_pulse_q, sec_pulse_d;

  logic tick, mode_press, inc_press;

  // Per-digit BCD increment; returns 00 once the field sits at its last value.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    if (v == last)            return 8'h00;
    else if (v[3:0] == 4'd9)  return {v[7:4] + 4'd1, 4'd0};
    else                      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign tick       = slow_s2_q & ~slow_prev_q;
  assign mode_press = tick & mode_smp_q & ~mode_s2_q;
  assign inc_press  = tick & inc_smp_q & ~inc_s2_q & ~mode_press;

  always_comb begin
    hour_d      = hour_q;
    min_d       = min_q;
    sec_d       = sec_q;
    sub_d       = sub_q;
    mode_d      = mode_q;
    blk_cnt_d   = blk_cnt_q;
    blink_d     = blink_q;
    sec_pulse_d = 1'b0;
    if (tick) begin
      if (mode_q != RUN && !mode_press) begin
        if (blk_cnt_q == BLK_LAST) begin
          blk_cnt_d = '0;
          blink_d   = ~blink_q;
        end else begin
          blk_cnt_d = blk_cnt_q + BLK_W'(1);
        end
      end
      case (mode_q)
        RUN: begin
          if (mode_press) begin
            mode_d    = SET_HOUR;
            blk_cnt_d = '0;
            blink_d   = 1'b1;
          end else if (sub_q == SUB_LAST) begin
            sub_d       = '0;
            sec_d       = bcd_inc(sec_q, 8'h59);
            sec_pulse_d = 1'b1;
            if (sec_q == 8'h59) begin
              min_d = bcd_inc(min_q, 8'h59);
              if (min_q == 8'h59) hour_d = bcd_inc(hour_q, 8'h23);
            end
          end else begin
            sub_d = sub_q + SUB_W'(1);
          end
        end
        SET_HOUR: begin
          if (mode_press) begin
            mode_d    = SET_MIN;
            blk_cnt_d = '0;
            blink_d   = 1'b1;
          end else if (inc_press) begin
            hour_d = bcd_inc(hour_q, 8'h23);
          end
        end
        SET_MIN: begin
          if (mode_press) begin
            mode_d    = RUN;
            sec_d     = 8'h00;
            sub_d     = '0;
            blk_cnt_d = '0;
            blink_d   = 1'b1;
          end else if (inc_press) begin
            min_d = bcd_inc(min_q, 8'h59);
          end
        end
        default: begin
          mode_d  = RUN;
          blink_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      slow_s1_q   <= 1'b0;
      slow_s2_q   <= 1'b0;
      slow_prev_q <= 1'b0;
      mode_s1_q   <= 1'b1;
      mode_s2_q   <= 1'b1;
      mode_smp_q  <= 1'b1;
      inc_s1_q    <= 1'b1;
      inc_s2_q    <= 1'b1;
      inc_smp_q   <= 1'b1;
      hour_q      <= 8'h00;
      min_q       <= 8'h00;
      sec_q       <= 8'h00;
      sub_q       <= '0;
      mode_q      <= RUN;
      blk_cnt_q   <= '0;
      blink_q     <= 1'b1;
      sec_pulse_q <= 1'b0;
    end else begin
      slow_s1_q   <= slow_clk;
      slow_s2_q   <= slow_s1_q;
      slow_prev_q <= slow_s2_q;
      mode_s1_q   <= key_mode_n;
      mode_s2_q   <= mode_s1_q;
      inc_s1_q    <= key_inc_n;
      inc_s2_q    <= inc_s1_q;
      // Keys are only looked at on ticks, which is what debounces them.
      if (tick) begin
        mode_smp_q <= mode_s2_q;
        inc_smp_q  <= inc_s2_q;
      end
      hour_q      <= hour_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      sub_q       <= sub_d;
      mode_q      <= mode_d;
      blk_cnt_q   <= blk_cnt_d;
      blink_q     <= blink_d;
      sec_pulse_q <= sec_pulse_d;
    end
  end

  assign hour_bcd  = hour_q;
  assign min_bcd   = min_q;
  assign sec_bcd   = sec_q;
  assign mode      = mode_q;
  assign blink     = blink_q;
  assign sec_pulse = sec_pulse_q;

endmodule
